// File: rtl/regfile_dual.sv
// Dual-write, quad-read integer register file for the dual-issue pipeline.
// x0 is hardwired to zero; same-cycle writes are bypassed to the read ports.
module regfile_dual #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [ADDR_W-1:0] raddr1a,
  input  logic [ADDR_W-1:0] raddr1b,
  input  logic [ADDR_W-1:0] raddr2a,
  input  logic [ADDR_W-1:0] raddr2b,
  output logic [DATA_W-1:0] rdata1a,
  output logic [DATA_W-1:0] rdata1b,
  output logic [DATA_W-1:0] rdata2a,
  output logic [DATA_W-1:0] rdata2b
);

  logic [DATA_W-1:0] regs_q [1:REG_NUM-1];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < REG_NUM);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural state must read as zero after reset, so the
      // whole array is cleared here; this costs a reset net on every flop.
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments take effect in order, so on an address
      // collision the slot-2 write below overrides slot 1.
      if (we1 && in_range(waddr1)) regs_q[waddr1] <= wdata1;
      if (we2 && in_range(waddr2)) regs_q[waddr2] <= wdata2;
    end
  end

  // Slot 2 is the younger instruction, so its retiring value takes priority.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic [ADDR_W-1:0] ra,
    input logic              we1_v,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1,
    input logic              we2_v,
    input logic [ADDR_W-1:0] wa2,
    input logic [DATA_W-1:0] wd2,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = '0;
    if (!rst_v && ra != '0) begin
      if (we2_v && wa2 == ra)      val = wd2;
      else if (we1_v && wa1 == ra) val = wd1;
      else                         val = stored;
    end
    return val;
  endfunction

  logic [DATA_W-1:0] stored_1a, stored_1b, stored_2a, stored_2b;

  always_comb begin
    stored_1a = in_range(raddr1a) ? regs_q[raddr1a] : '0;
    stored_1b = in_range(raddr1b) ? regs_q[raddr1b] : '0;
    stored_2a = in_range(raddr2a) ? regs_q[raddr2a] : '0;
    stored_2b = in_range(raddr2b) ? regs_q[raddr2b] : '0;
    rdata1a = read_port(rst, raddr1a, we1, waddr1, wdata1, we2, waddr2, wdata2, stored_1a);
    rdata1b = read_port(rst, raddr1b, we1, waddr1, wdata1, we2, waddr2, wdata2, stored_1b);
    rdata2a = read_port(rst, raddr2a, we1, waddr1, wdata1, we2, waddr2, wdata2, stored_2a);
    rdata2b = read_port(rst, raddr2b, we1, waddr1, wdata1, we2, waddr2, wdata2, stored_2b);
  end

endmodule

// File: tb/tb_regfile_dual.sv
// Scoreboard bench for regfile_dual: directed scenarios followed by random
// traffic, checked against an array-based architectural model.
module tb_regfile_dual;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we1, we2;
  logic [AW-1:0] waddr1, waddr2;
  logic [DW-1:0] wdata1, wdata2;
  logic [AW-1:0] raddr1a, raddr1b, raddr2a, raddr2b;
  logic [DW-1:0] rdata1a, rdata1b, rdata2a, rdata2b;

  regfile_dual #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .raddr1a(raddr1a), .raddr1b(raddr1b), .raddr2a(raddr2a), .raddr2b(raddr2b),
    .rdata1a(rdata1a), .rdata1b(rdata1b), .rdata2a(rdata2a), .rdata2b(rdata2b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model [32];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  task automatic check(input string name, input int c, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  // Architectural expectation for one read port in the current cycle.
  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] ra);
    if (rst || ra == 0)              return '0;
    if (we2 && waddr2 == ra)         return wdata2;
    if (we1 && waddr1 == ra)         return wdata1;
    return model[ra];
  endfunction

  task automatic cycle(input logic r,
                       input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic [AW-1:0] r1a, input logic [AW-1:0] r1b,
                       input logic [AW-1:0] r2a, input logic [AW-1:0] r2b);
    exp_t e;
    rst = r; we1 = e1; waddr1 = a1; wdata1 = d1; we2 = e2; waddr2 = a2; wdata2 = d2;
    raddr1a = r1a; raddr1b = r1b; raddr2a = r2a; raddr2b = r2b;
    e.cyc = cyc;
    e.port = 0; e.exp = expect_read(r1a); sb_q.push_back(e);
    e.port = 1; e.exp = expect_read(r1b); sb_q.push_back(e);
    e.port = 2; e.exp = expect_read(r2a); sb_q.push_back(e);
    e.port = 3; e.exp = expect_read(r2b); sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else begin
      if (e1 && a1 != 0) model[a1] = d1;
      if (e2 && a2 != 0) model[a2] = d2;
    end
    cyc++;
    #1;
  endtask

  // Monitor: outputs are combinational, so every pushed expectation is due
  // at the falling edge of the cycle that issued it.
  initial begin
    exp_t e;
    logic [DW-1:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.port)
          0:       got = rdata1a;
          1:       got = rdata1b;
          2:       got = rdata2a;
          default: got = rdata2b;
        endcase
        case (e.port)
          0:       check("rdata1a", e.cyc, got, e.exp);
          1:       check("rdata1b", e.cyc, got, e.exp);
          2:       check("rdata2a", e.cyc, got, e.exp);
          default: check("rdata2b", e.cyc, got, e.exp);
        endcase
      end
    end
  end

  initial begin
    logic r, e1, e2;
    logic [AW-1:0] a1, a2, ra [4];
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b1; we1 = 1'b0; we2 = 1'b0; waddr1 = '0; waddr2 = '0;
    wdata1 = '0; wdata2 = '0; raddr1a = '0; raddr1b = '0; raddr2a = '0; raddr2b = '0;
    @(posedge clk); #1;

    // Initial reset, outputs forced to zero while high.
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 5, 17, 31);
    // Reset beats a simultaneous write.
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 0, 1);
    cycle(1, 1, 5, 32'h11, 0, 0, 0, 5, 5, 5, 5);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
    // Basic write with bypass, then from storage.
    cycle(0, 1, 3, 32'h12345678, 0, 0, 0, 3, 0, 3, 2);
    cycle(0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
    // Dual write to different registers.
    cycle(0, 1, 7, 32'hA, 1, 8, 32'hB, 7, 8, 7, 8);
    cycle(0, 0, 0, 0, 0, 0, 0, 8, 7, 7, 8);
    // Collision: slot 2 wins in bypass and storage.
    cycle(0, 1, 9, 32'h1, 1, 9, 32'h2, 9, 9, 9, 9);
    cycle(0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 9);
    // x0 writes are discarded, including bypass.
    cycle(0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Bypass overrides stale storage on all four ports.
    cycle(0, 1, 4, 32'h10, 0, 0, 0, 1, 2, 3, 4);
    cycle(0, 0, 0, 0, 1, 4, 32'h20, 4, 4, 4, 4);
    cycle(0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 4);
    // Top address boundary.
    cycle(0, 1, 31, 32'hCAFEF00D, 0, 0, 0, 31, 30, 31, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 31, 31, 1, 31);

    // Random traffic; narrow address window half the time to force hits.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      e1 = $urandom_range(0, 1) == 1;
      e2 = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        a1 = AW'($urandom_range(0, 3));
        a2 = AW'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) ra[k] = AW'($urandom_range(0, 3));
      end else begin
        a1 = AW'($urandom);
        a2 = AW'($urandom);
        for (int k = 0; k < 4; k++) ra[k] = AW'($urandom);
      end
      cycle(r, e1, a1, $urandom, e2, a2, $urandom, ra[0], ra[1], ra[2], ra[3]);
    end

    we1 = 1'b0; we2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dual.md
Name: regfile_dual

Overview:
- Integer register file for the dual-issue pipeline; sits directly downstream of the WB stage.
- Consumes the two WB-qualified write-enable/address/data pairs, one per issue slot.
- Provides four combinational read ports for the ID stage: two source operands per issue slot.
- Same-cycle write-to-read bypass, so ID never reads a stale value for a register being retired in the same cycle.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
REG_NUM, 32, number of architectural registers (x0..x31)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
we1  input  1  write enable, slot 1 (rfwe_out1 from WB)
waddr1  input  ADDR_W  write address, slot 1
wdata1  input  DATA_W  write data, slot 1
we2  input  1  write enable, slot 2 (rfwe_out2 from WB)
waddr2  input  ADDR_W  write address, slot 2
wdata2  input  DATA_W  write data, slot 2
raddr1a  input  ADDR_W  read address, slot 1 operand rs1
raddr1b  input  ADDR_W  read address, slot 1 operand rs2
raddr2a  input  ADDR_W  read address, slot 2 operand rs1
raddr2b  input  ADDR_W  read address, slot 2 operand rs2
rdata1a  output  DATA_W  read data for raddr1a
rdata1b  output  DATA_W  read data for raddr1b
rdata2a  output  DATA_W  read data for raddr2a
rdata2b  output  DATA_W  read data for raddr2b

Behaviour:
- Storage: registers x1..x(REG_NUM-1), each DATA_W wide.
- x0 is not stored. Reads of address 0 always return 0. Writes to address 0 are discarded, including the bypass path.
- Reset:
  - rst sampled high at a rising edge clears x1..x31 to 0.
  - While rst is high, all writes are ignored.
  - While rst is high, all four rdata outputs are forced to 0, combinationally.
  - Reset asserted in the same cycle as writes: reset wins and the writes are lost.
- Write timing:
  - On a rising edge with rst low, each port with weN=1 and waddrN!=0 updates its register with wdataN.
  - The new value is visible in storage from the next cycle.
- Write collision (we1 & we2 & waddr1==waddr2, nonzero):
  - Slot 2 wins and slot 1's data is dropped.
  - WB normally prevents this; the rule is defensive and still required.
- Read timing:
  - Reads are purely combinational from raddr; there are no read enables.
  - Read latency is 0 cycles.
- Bypass priority for each read port with raddr!=0 and rst=0, first match wins:
  1. we2 & waddr2==raddr -> wdata2
  2. we1 & waddr1==raddr -> wdata1
  3. otherwise -> stored value
- Bypass applies only in the cycle the write is presented. After the edge, storage holds the same value.
- Address widths are exact; no wrap-around or aliasing. All 2^ADDR_W addresses are valid when REG_NUM=32.
- Read ports are independent. Any combination of equal read addresses returns identical data.
- No combinational path from write inputs to storage; storage changes only at clock edges.

Test Plan:
1. Reset: preload x5=0xDEADBEEF, then pulse rst for 1 cycle with we1=1, waddr1=5, wdata1=0x11 -> after the edge x5 reads 0; all rdata are 0 while rst is high.
2. Basic write/read: cycle 0 we1=1, waddr1=3, wdata1=0x12345678, raddr1a=3 -> rdata1a=0x12345678 in cycle 0 (bypass) and in cycle 1 with we1=0 (storage).
3. Dual write, different addresses: we1 writes x7=0xA, we2 writes x8=0xB in the same cycle; next cycle raddr2a=7, raddr2b=8 -> rdata2a=0xA, rdata2b=0xB.
4. Collision: we1 x9=0x1 and we2 x9=0x2 in the same cycle -> bypassed rdata for raddr=9 is 0x2 that cycle, and the stored x9 is 0x2 the next cycle.
5. x0: we1=1, waddr1=0, wdata1=0xFFFFFFFF; raddr1a=0 -> rdata1a=0 in the same cycle and the next.
6. Bypass vs. stale storage: x4=0x10 stored; we2 writes x4=0x20 while all four raddr=4 -> all four rdata=0x20 that cycle and 0x20 after the edge.
